// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
//   Reader side of a multiplexed 7-segment display bus. Samples the
//   active-low segment lines and active-low digit selects, waits for each
//   digit pattern to settle, decodes it to BCD (illegal patterns -> 4'hF with
//   an error flag) and publishes a full frame once every digit slot has been
//   captured. A frame that stalls part-way is discarded after a timeout.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   seg_in       segments a..g (seg_in[6]=a .. seg_in[0]=g), active-low
//   dig_sel_n    digit selects, active-low, bit i = digit i
//   digits       committed frame, digit i at [4i+3:4i]
//   digit_err    bit i set when digit i held an illegal pattern
//   frame_valid  1-cycle pulse when digits/digit_err update
//   timeout      1-cycle pulse when a partial frame is discarded
//
// States
//   IDLE   | no single digit selected
//   SETTLE | one digit selected, counting identical samples
//   HOLD   | current window captured, waiting for the bus to move on

module seg7_scan_reader #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel_n,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      frame_valid,
    output logic                      timeout
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    localparam logic [7:0]    STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(TIMEOUT_CYCLES);

    logic [6:0]              seg_s1, seg_s;
    logic [NUM_DIGITS-1:0]   sel_s1, sel_s;
    logic [SW-1:0]           smp, smp_prev;
    logic                    changed;
    logic [NUM_DIGITS-1:0]   sel_act;
    logic                    sel_valid;

    logic [1:0]              state;
    logic [7:0]              stab_cnt;
    logic                    capture;

    logic [3:0]              dec_val;
    logic                    dec_err;

    logic [4*NUM_DIGITS-1:0] slot_val;
    logic [NUM_DIGITS-1:0]   slot_err;
    logic [NUM_DIGITS-1:0]   seen;
    logic [NUM_DIGITS-1:0]   seen_next;
    logic [IW-1:0]           idle_cnt;
    logic                    commit;
    logic                    to_hit;

    // Synchronizers idle at all-ones: no digit selected, all segments dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1   <= '1;
            seg_s    <= '1;
            sel_s1   <= '1;
            sel_s    <= '1;
            smp_prev <= '1;
        end else begin
            seg_s1   <= seg_in;
            seg_s    <= seg_s1;
            sel_s1   <= dig_sel_n;
            sel_s    <= sel_s1;
            smp_prev <= smp;
        end
    end

    assign smp       = {sel_s, seg_s};
    assign changed   = (smp != smp_prev);
    assign sel_act   = ~sel_s;
    // exactly one select low: non-zero and a power of two
    assign sel_valid = (sel_act != '0) &&
                       ((sel_act & (sel_act - NUM_DIGITS'(1))) == '0);

    // The STABLE_CYCLES-th identical sample is the one seen while the count
    // already holds STABLE_CYCLES-1.
    assign capture = (state == SETTLE) && sel_valid && !changed &&
                     (stab_cnt == STAB_LAST);

    always_comb begin
        dec_val = 4'hF;
        case (seg_s)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            default:    dec_val = 4'hF;
        endcase
        // no legal pattern decodes to F
        dec_err = (dec_val == 4'hF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            stab_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state    <= SETTLE;
                        stab_cnt <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (!sel_valid) begin
                        state    <= IDLE;
                        stab_cnt <= '0;
                    end else if (changed) begin
                        stab_cnt <= 8'd1;
                    end else if (capture) begin
                        state    <= HOLD;
                        stab_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        if (sel_valid) begin
                            state    <= SETTLE;
                            stab_cnt <= 8'd1;
                        end else begin
                            state    <= IDLE;
                            stab_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    stab_cnt <= '0;
                end
            endcase
        end
    end

    assign commit = &seen;
    // A capture on the same cycle restarts the idle window, so it suppresses
    // the timeout; a completing frame commits rather than being discarded.
    assign to_hit = (seen != '0) && !commit && !capture &&
                    (idle_cnt == IDLE_LAST);

    always_comb begin
        seen_next = (commit || to_hit) ? '0 : seen;
        if (capture) begin
            seen_next = seen_next | sel_act;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_val    <= '0;
            slot_err    <= '0;
            seen        <= '0;
            idle_cnt    <= '0;
            digits      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            frame_valid <= commit;
            timeout     <= to_hit;
            seen        <= seen_next;

            if (commit) begin
                digits    <= slot_val;
                digit_err <= slot_err;
            end

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && sel_act[i]) begin
                    slot_val[4*i +: 4] <= dec_val;
                    slot_err[i]        <= dec_err;
                end
            end

            if (capture) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_SAT) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;

    localparam int N = 4;
    localparam int S = 4;
    localparam int T = 16;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PX = 7'b1111111;

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     seg_in;
    logic [N-1:0]   dig_sel_n;
    logic [4*N-1:0] digits;
    logic [N-1:0]   digit_err;
    logic           frame_valid;
    logic           timeout;

    seg7_scan_reader #(
        .NUM_DIGITS(N),
        .STABLE_CYCLES(S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .dig_sel_n(dig_sel_n),
        .digits(digits),
        .digit_err(digit_err),
        .frame_valid(frame_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int fv_cnt = 0;
    int to_cnt = 0;
    int to_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        dig_sel_n = sel;
        seg_in    = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int d, input logic [6:0] seg, input int n);
        logic [3:0] one;
        one = 4'b0001 << d;
        drive(~one, seg, n);
    endtask

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [15:0]     exp_digits;
        logic [3:0]      exp_err;
    } frame_vec_t;

    frame_vec_t vecs [4];

    initial begin
        int fv_base;
        int to_base;
        int t0;

        vecs[0].seg = {P1, P4, P1, P3};       vecs[0].exp_digits = 16'h1413; vecs[0].exp_err = 4'b0000;
        vecs[1].seg = {P9, PX, P5, P0};       vecs[1].exp_digits = 16'h9F50; vecs[1].exp_err = 4'b0100;
        vecs[2].seg = {P2, P6, P7, P8};       vecs[2].exp_digits = 16'h2678; vecs[2].exp_err = 4'b0000;
        vecs[3].seg = {P7, P3, P2, 7'b1111110}; vecs[3].exp_digits = 16'h732F; vecs[3].exp_err = 4'b0001;

        rst       = 1'b1;
        seg_in    = PX;
        dig_sel_n = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {digits, digit_err, frame_valid, timeout}, 0);
        rst = 1'b0;
        fv_base = fv_cnt;
        drive(4'hF, PX, 10);
        chk("idle_after_reset", {fv_cnt - fv_base, 16'(digits)}, 0);

        // full frames
        for (int v = 0; v < 4; v++) begin
            fv_base = fv_cnt;
            for (int d = 0; d < N; d++) drive_digit(d, vecs[v].seg[d], 10);
            drive(4'hF, PX, 6);
            chk($sformatf("frame%0d_pulses", v), fv_cnt - fv_base, 1);
            chk($sformatf("frame%0d_digits", v), digits, vecs[v].exp_digits);
            chk($sformatf("frame%0d_err", v), digit_err, vecs[v].exp_err);
        end

        // glitch: digit 0 held only S-1 cycles must not be captured
        fv_base = fv_cnt;
        drive_digit(0, P5, S - 1);
        drive(4'hF, PX, 3);
        drive_digit(1, P6, 10);
        drive_digit(2, P7, 10);
        drive_digit(3, P8, 10);
        chk("glitch_no_frame", fv_cnt - fv_base, 0);
        drive_digit(0, P5, 100);
        chk("long_hold_frame", fv_cnt - fv_base, 1);
        chk("long_hold_digits", digits, 16'h8765);

        // digit 0 was captured once only; remaining digits alone cannot finish a frame
        to_base = to_cnt;
        drive_digit(1, P1, 10);
        drive_digit(2, P1, 10);
        drive_digit(3, P1, 10);
        drive(4'hF, PX, 30);
        chk("no_recapture_frame", fv_cnt - fv_base, 1);
        chk("partial_timeout", to_cnt - to_base, 1);
        chk("partial_keeps_digits", digits, 16'h8765);

        // bad selects: nothing captured, so no timeout either
        fv_base = fv_cnt;
        to_base = to_cnt;
        drive(4'b0011, P8, 50);
        drive(4'b1111, P8, 50);
        drive(4'hF, PX, 30);
        chk("badsel_no_frame", fv_cnt - fv_base, 0);
        chk("badsel_no_timeout", to_cnt - to_base, 0);

        // timeout after two captures
        fv_base = fv_cnt;
        to_base = to_cnt;
        drive_digit(0, P2, 10);
        t0 = cyc;
        drive_digit(1, P4, 40);
        chk("timeout_count", to_cnt - to_base, 1);
        chk("timeout_when", (to_cyc >= t0 + 20 && to_cyc <= t0 + 24) ? 1 : 0, 1);
        chk("timeout_no_frame", fv_cnt - fv_base, 0);
        chk("timeout_digits", digits, 16'h8765);
        chk("timeout_err", digit_err, 4'b0000);
        // seen was cleared: digits 2,3 alone cannot complete the frame
        drive_digit(2, P1, 10);
        drive_digit(3, P1, 10);
        drive(4'hF, PX, 30);
        chk("timeout_cleared_seen", fv_cnt - fv_base, 0);

        // reset in the middle of SETTLE
        drive_digit(0, P3, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_outputs", {digits, digit_err, frame_valid, timeout}, 0);
        seg_in    = PX;
        dig_sel_n = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fv_base = fv_cnt;
        drive_digit(1, P1, 10);
        drive_digit(2, P1, 10);
        drive_digit(3, P1, 10);
        drive(4'hF, PX, 30);
        chk("midreset_no_frame", fv_cnt - fv_base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
